// File: rtl/lfsr_arb_pkg.sv
// Shared types and default sizing for the LFSR-fed random-value arbiter.
package lfsr_arb_pkg;
  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_WIDTH     = 4;
  localparam int DEF_MAX_TRIES = 8;

  typedef enum logic [1:0] {IDLE, SAMPLE, DELIVER, GAP} state_t;
endpackage

// File: rtl/lfsr_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] oh,
  output logic [IW-1:0]      idx,
  output logic               any
);
  logic [IW-1:0] jj;

  always_comb begin
    oh  = '0;
    idx = '0;
    any = 1'b0;
    jj  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      jj = IW'((int'(ptr) + i) % NUM_REQ);
      if (!any && req[jj]) begin
        any    = 1'b1;
        oh[jj] = 1'b1;
        idx    = jj;
      end
    end
  end
endmodule

// File: rtl/lfsr_arbiter.sv
// Shares one LFSR word among NUM_REQ requesters, one delivery per grant.
// LFSR_ARBITER_REJECT_EN enables rejection sampling against each requester's limit.
import lfsr_arb_pkg::*;

module lfsr_arbiter #(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int WIDTH     = DEF_WIDTH,
  parameter int MAX_TRIES = DEF_MAX_TRIES
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         rnd_in,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] limit,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]         rnd_out,
  output logic                     valid,
  output logic                     busy
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             state, state_nx;
  logic [IW-1:0]      ptr, win, pick_idx;
  logic [NUM_REQ-1:0] pick_oh, gnt_q;
  logic               pick_any;
  logic [WIDTH-1:0]   rnd_q, take_val;
  logic               abort, take;

  rr_picker #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .req (req),
    .ptr (ptr),
    .oh  (pick_oh),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign abort = (state == SAMPLE) && !req[win];

`ifdef LFSR_ARBITER_REJECT_EN
  localparam int TW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  logic [TW-1:0]    tries;
  logic [WIDTH-1:0] lim_w;
  logic             fits, clamp;

  assign lim_w    = limit[int'(win)*WIDTH +: WIDTH];
  assign fits     = (rnd_in <= lim_w);
  assign clamp    = (tries == TW'(MAX_TRIES-1));
  assign take     = !abort && (fits || clamp);
  assign take_val = fits ? rnd_in : lim_w;

  always_ff @(posedge clock) begin
    if (!reset)                                tries <= '0;
    else if (state != SAMPLE || abort || take) tries <= '0;
    else                                       tries <= tries + 1'b1;
  end
`else
  logic unused_limit;
  assign unused_limit = ^limit;
  assign take         = !abort;
  assign take_val     = rnd_in;
`endif

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (pick_any) state_nx = SAMPLE;
      SAMPLE:  if (abort) state_nx = GAP; else if (take) state_nx = DELIVER;
      DELIVER: state_nx = GAP;
      GAP:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    valid = (state == DELIVER);
    busy  = (state != IDLE);
  end

  // Pointer moves at grant time so an aborted requester still loses its turn.
  always_ff @(posedge clock) begin
    if (!reset) begin
      gnt_q <= '0;
      rnd_q <= '0;
      ptr   <= '0;
      win   <= '0;
    end else begin
      case (state)
        IDLE: if (pick_any) begin
          gnt_q <= pick_oh;
          win   <= pick_idx;
          ptr   <= (pick_idx == IW'(NUM_REQ-1)) ? '0 : pick_idx + 1'b1;
        end
        SAMPLE: begin
          if (abort)     gnt_q <= '0;
          else if (take) rnd_q <= take_val;
        end
        DELIVER: gnt_q <= '0;
        default: ;
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign rnd_out = rnd_q;
endmodule

// File: tb/tb_lfsr_arbiter.sv
// Directed bench for lfsr_arbiter; rejection/clamp cases run when LFSR_ARBITER_REJECT_EN is set.
module tb_lfsr_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  rnd_in;
  logic [3:0]  req;
  logic [15:0] limit;
  logic [3:0]  gnt;
  logic [3:0]  rnd_out;
  logic        valid, busy;

  int checks = 0;
  int errors = 0;
  logic [3:0] last_rnd;

  lfsr_arbiter dut (
    .clock(clk), .reset(reset), .rnd_in(rnd_in), .req(req), .limit(limit),
    .gnt(gnt), .rnd_out(rnd_out), .valid(valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b0; req = '0; limit = '1; rnd_in = '0;
    tick; tick;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (rnd_out !== 4'h0) begin errors++; $display("FAIL reset_rnd: got %h want 0", rnd_out); end
    reset = 1'b1;
  endtask

  task automatic test_single;
    req = 4'b0001; limit = 16'hFFFF; rnd_in = 4'h9;
    tick;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt: got %b want 0001", gnt); end
    checks++; if (valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL single_sample: got valid=%b busy=%b want 0 1", valid, busy); end
    tick;
    checks++; if (valid !== 1'b1 || rnd_out !== 4'h9 || gnt !== 4'b0001) begin
      errors++; $display("FAIL single_deliver: got valid=%b rnd=%h gnt=%b want 1 9 0001", valid, rnd_out, gnt); end
    req = 4'b0000;
    tick;
    checks++; if (gnt !== 4'b0000 || valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL single_gap: got gnt=%b valid=%b busy=%b want 0000 0 1", gnt, valid, busy); end
    tick;
    checks++; if (busy !== 1'b0 || rnd_out !== 4'h9) begin
      errors++; $display("FAIL single_idle: got busy=%b rnd=%h want 0 9", busy, rnd_out); end
    last_rnd = 4'h9;
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_g;
    reset = 1'b0; tick; reset = 1'b1;
    req = 4'b1111; limit = 16'hFFFF; rnd_in = 4'h5;
    for (int c = 1; c <= 18; c++) begin
      tick;
      if (c % 4 == 1) begin
        exp_g = 4'b0001 << (((c - 1) / 4) % 4);
        checks++; if (gnt !== exp_g) begin errors++; $display("FAIL rr_gnt c=%0d: got %b want %b", c, gnt, exp_g); end
      end
      if (c % 4 == 2) begin
        checks++; if (valid !== 1'b1 || rnd_out !== 4'h5) begin
          errors++; $display("FAIL rr_valid c=%0d: got valid=%b rnd=%h want 1 5", c, valid, rnd_out); end
      end
    end
    req = 4'b0000;
    tick; tick;
    last_rnd = 4'h5;
  endtask

`ifdef LFSR_ARBITER_REJECT_EN
  task automatic test_reject;
    req = 4'b0010; limit = 16'hFF3F; rnd_in = 4'hC;
    tick;
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL rej_gnt: got %b want 0010", gnt); end
    tick;
    checks++; if (valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL rej_first: got valid=%b busy=%b want 0 1", valid, busy); end
    rnd_in = 4'hA;
    tick;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rej_second: got valid=%b want 0", valid); end
    rnd_in = 4'h2;
    tick;
    checks++; if (valid !== 1'b1 || rnd_out !== 4'h2) begin
      errors++; $display("FAIL rej_deliver: got valid=%b rnd=%h want 1 2", valid, rnd_out); end
    req = 4'b0000;
    tick; tick;
    last_rnd = 4'h2;
  endtask

  task automatic test_clamp;
    int first_c;
    logic [3:0] got_rnd;
    first_c = 0; got_rnd = '0;
    req = 4'b0100; limit = 16'hF1FF; rnd_in = 4'hE;
    for (int c = 1; c <= 14; c++) begin
      tick;
      if (valid === 1'b1 && first_c == 0) begin
        first_c = c; got_rnd = rnd_out; req = 4'b0000;
      end
    end
    checks++; if (first_c != 9) begin errors++; $display("FAIL clamp_latency: got cycle %0d want 9", first_c); end
    checks++; if (got_rnd !== 4'h1) begin errors++; $display("FAIL clamp_value: got %h want 1", got_rnd); end
    last_rnd = 4'h1;
  endtask
`else
  task automatic test_no_reject;
    req = 4'b0001; limit = 16'h0000; rnd_in = 4'h7;
    tick;
    checks++; if (gnt !== 4'b0001 || valid !== 1'b0) begin
      errors++; $display("FAIL norej_gnt: got gnt=%b valid=%b want 0001 0", gnt, valid); end
    tick;
    checks++; if (valid !== 1'b1 || rnd_out !== 4'h7) begin
      errors++; $display("FAIL norej_deliver: got valid=%b rnd=%h want 1 7", valid, rnd_out); end
    req = 4'b0000;
    tick; tick;
    last_rnd = 4'h7;
  endtask
`endif

  task automatic test_abort;
    req = 4'b0001; limit = 16'h0000; rnd_in = 4'hF;
    tick;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL abort_gnt: got %b want 0001", gnt); end
    req = 4'b0000;
    tick;
    checks++; if (valid !== 1'b0 || gnt !== 4'b0000 || busy !== 1'b1) begin
      errors++; $display("FAIL abort_gap: got valid=%b gnt=%b busy=%b want 0 0000 1", valid, gnt, busy); end
    tick;
    checks++; if (busy !== 1'b0 || rnd_out !== last_rnd) begin
      errors++; $display("FAIL abort_idle: got busy=%b rnd=%h want 0 %h", busy, rnd_out, last_rnd); end
  endtask

  task automatic test_reset_mid;
    req = 4'b1111; limit = 16'h0000; rnd_in = 4'hF;
    tick;
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL ptr_after_abort: got %b want 0010", gnt); end
    reset = 1'b0;
    tick;
    checks++; if (gnt !== 4'b0000 || busy !== 1'b0 || valid !== 1'b0 || rnd_out !== 4'h0) begin
      errors++; $display("FAIL reset_mid: got gnt=%b busy=%b valid=%b rnd=%h want 0000 0 0 0", gnt, busy, valid, rnd_out); end
    reset = 1'b1;
    tick;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL reset_ptr: got %b want 0001", gnt); end
    req = 4'b0000;
    tick; tick; tick;
  endtask

  initial begin
    test_reset;
    test_single;
    test_round_robin;
`ifdef LFSR_ARBITER_REJECT_EN
    test_reject;
    test_clamp;
`else
    test_no_reject;
`endif
    test_abort;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
